// File: rtl/wdt_rib.sv
// Watchdog timer on a rib slave port: first expiry raises an interrupt,
// a second unfed expiry emits a fixed-width reset-request pulse.
module wdt_rib #(
    parameter int unsigned PRESCALE  = 16,
    parameter int unsigned RST_PULSE = 8,
    parameter logic [31:0] FEED_KEY  = 32'h5A5A_A5A5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        int_sig_o,
    output logic        wdt_rst_o
);

    localparam logic [15:0] PRE_MAX   = 16'(PRESCALE - 1);
    localparam logic [7:0]  PULSE_MAX = 8'(RST_PULSE - 1);

    typedef enum logic {IDLE, PULSE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  pulse_q, pulse_d;
    logic        en_q, rst_en_q, int_en_q, pend_q, int_q;
    logic [31:0] load_q, count_q;
    logic [15:0] pre_q;

    logic [7:0]  off;
    logic        sel_ctrl, sel_load, feed;
    logic        tick, trigger;
    logic        addr_unused;

    assign off         = addr_i[7:0];
    assign addr_unused = ^addr_i[31:8];

    assign sel_ctrl = we_i && (off == 8'h00);
    assign sel_load = we_i && (off == 8'h04);
    assign feed     = we_i && (off == 8'h0C) && (data_i == FEED_KEY);

    assign tick    = en_q && (pre_q == PRE_MAX);
    // A feed on the trigger edge wins, so it also blocks the pulse.
    assign trigger = tick && (count_q == '0) && pend_q
                     && rst_en_q && !feed;

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q     <= 1'b0;
            rst_en_q <= 1'b0;
            int_en_q <= 1'b0;
            pend_q   <= 1'b0;
            load_q   <= '1;
            count_q  <= '1;
            pre_q    <= '0;
            int_q    <= 1'b0;
        end else begin
            if (sel_ctrl) begin
                en_q     <= data_i[0];
                rst_en_q <= data_i[1];
                int_en_q <= data_i[2];
            end
            if (sel_load)
                load_q <= data_i;
            if (feed) begin
                count_q <= load_q;
                pre_q   <= '0;
                pend_q  <= 1'b0;
            end else begin
                if (!en_q || tick)
                    pre_q <= '0;
                else
                    pre_q <= pre_q + 16'd1;
                if (tick) begin
                    if (count_q != '0) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        count_q <= load_q;
                        pend_q  <= 1'b1;
                    end
                end
            end
            int_q <= pend_q & int_en_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = PULSE;
                    pulse_d = PULSE_MAX;
                end
            end
            PULSE: begin
                if (pulse_q == '0)
                    state_d = IDLE;
                else
                    pulse_d = pulse_q - 8'd1;
            end
        endcase
    end

    always_comb begin
        data_o = '0;
        case (off)
            8'h00:   data_o = {28'd0, pend_q, int_en_q, rst_en_q, en_q};
            8'h04:   data_o = load_q;
            8'h08:   data_o = count_q;
            default: data_o = {31'd0, addr_unused & 1'b0};
        endcase
    end

    assign int_sig_o = int_q;
    assign wdt_rst_o = (state_q == PULSE);

endmodule

// File: doc/wdt_rib.md
Name: wdt_rib

Overview:
- Watchdog timer that attaches as a rib slave peripheral, decoded in its own slave slot beside timer_0, with the same data/addr/we slave interface as the timer.
- Counts down from a software-loaded value. The first expiry raises an interrupt, which is OR-ed into int_flag. A second expiry without a feed asserts a reset-request pulse, which the SoC ORs with the jtag reset request into the core reset path.

Parameters:
- PRESCALE, 16, number of clk cycles per counter decrement (range 1..65535).
- RST_PULSE, 8, width in clk cycles of the wdt_rst_o pulse (range 1..255).
- FEED_KEY, 32'h5A5A_A5A5, value that must be written to FEED to reload the counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active low
- we_i  in  1  write enable from rib slave port
- addr_i  in  32  byte address; only addr_i[7:0] decoded
- data_i  in  32  write data
- data_o  out  32  read data
- int_sig_o  out  1  watchdog interrupt, level
- wdt_rst_o  out  1  reset request pulse, active high

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-low. While rst==0 at a posedge, every register below takes its reset value.
- Register map (addr_i[7:0]); any other offset reads 0 and ignores writes:
  - 0x00 CTRL, RW. bit0 EN, bit1 RST_EN, bit2 INT_EN, bit3 PEND (RO; cleared only by feed or reset), bits31:4 read 0.
  - 0x04 LOAD, RW, 32 bit. Reload value.
  - 0x08 COUNT, RO, 32 bit. Current count.
  - 0x0C FEED, WO, reads 0.
- Reset values: CTRL=0, LOAD=32'hFFFF_FFFF, COUNT=32'hFFFF_FFFF, prescaler=0, pulse counter=0, int_sig_o=0, wdt_rst_o=0.
- Reads: data_o is combinational from addr_i, with zero-cycle latency, matching the other rib slaves.
- Writes: take effect at the posedge where we_i==1. The new value is visible on a read in the next cycle.
- Prescaler:
  - When EN==1, the prescaler counts 0..PRESCALE-1. A tick occurs on the cycle it equals PRESCALE-1; it then wraps to 0.
  - When EN==0, the prescaler is held at 0 and COUNT is frozen.
- Counter, on a tick:
  - COUNT!=0: COUNT <= COUNT-1.
  - COUNT==0 and PEND==0: PEND <= 1, COUNT <= LOAD (first expiry).
  - COUNT==0 and PEND==1 and RST_EN==1: start a reset pulse, COUNT <= LOAD, PEND stays 1.
  - COUNT==0 and PEND==1 and RST_EN==0: COUNT <= LOAD, no further action.
- Feed:
  - A write to FEED with data_i==FEED_KEY sets COUNT <= LOAD, prescaler <= 0 and PEND <= 0 at the same edge.
  - Feed has priority over a coincident tick.
  - Any other FEED data is ignored.
- Writing LOAD does not change COUNT until the next reload or feed.
- Writing CTRL with EN 1->0 holds COUNT and PEND. Re-enabling resumes from the held count with the prescaler at 0.
- int_sig_o = PEND & INT_EN, registered. It rises one cycle after PEND sets, or one cycle after INT_EN is written to 1 while PEND==1.
- Reset-pulse FSM, states IDLE and PULSE:
  - IDLE -> PULSE on the trigger tick, loading the pulse counter with RST_PULSE-1.
  - In PULSE: wdt_rst_o=1 (registered, first high cycle is the one after the trigger edge); the counter decrements each cycle; -> IDLE when it is 0.
  - The pulse is exactly RST_PULSE cycles long and cannot be retriggered or cut short by feed or register writes.
  - Only rst==0 aborts it, returning to IDLE with wdt_rst_o=0.
- Boundaries:
  - LOAD==0: every tick is an expiry (first sets PEND, second triggers reset if RST_EN).
  - COUNT decrement never wraps below 0.
  - A feed on the same edge as the trigger tick wins, so no pulse starts.

Test Plan:
1. Reset then read: drive rst=0 for 2 cycles, then read 0x00/0x04/0x08 -> 0, FFFF_FFFF, FFFF_FFFF; int_sig_o=0; wdt_rst_o=0.
2. Countdown: PRESCALE=4, write LOAD=3, FEED key, CTRL=0x5 -> COUNT reads 3,2,1,0 at 4-cycle steps. At the next tick PEND=1 and COUNT=3; int_sig_o goes high 1 cycle later.
3. Second expiry: as in scenario 2 with CTRL=0x7 and no feed -> wdt_rst_o high for exactly 8 cycles, starting the cycle after the second zero-tick. PEND remains 1.
4. Feed: during scenario 3 setup, write FEED=0x5A5A_A5A5 after the first expiry -> PEND=0 and int_sig_o=0 next cycle, COUNT=LOAD, no reset pulse. Writing FEED=0x1234_5678 changes nothing.
5. Collision: a FEED key write on the same edge as the trigger tick -> no wdt_rst_o, COUNT=LOAD, PEND=0.
6. Reset mid-pulse: assert rst=0 during the 3rd pulse cycle -> wdt_rst_o=0 after that edge, all registers at reset values, no resumption after rst returns to 1.
